gesture_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the gesture bounding-box tracker. Detects frame start/end from vsync,

---
 rtl/gesture_pkg.sv | 25 ++
 rtl/seq_div.sv | 89 ++++++++
 rtl/gesture_frame_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_gesture_frame_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared types and defaults for the gesture frame sequencer.
// Coordinate, perimeter and quotient widths plus the FSM state encoding.
package gesture_pkg;

  localparam int DW_DEF = 12;
  localparam int PW_DEF = 20;
  localparam int QW_DEF = 24;

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_MULT   = 3'd3,
    ST_DIV    = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  typedef struct packed {
    logic [DW_DEF-1:0] x_min;
    logic [DW_DEF-1:0] x_max;
    logic [DW_DEF-1:0] y_min;
    logic [DW_DEF-1:0] y_max;
  } box_t;

endpackage

// File: rtl/seq_div.sv
// Restoring serial divider, one quotient bit per cycle.
// The first bit is resolved on the start cycle, so QW cycles elapse before done.
module seq_div #(
  parameter int QW = 24,
  parameter int PW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [QW-1:0] dividend,
  input  logic [PW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(QW + 1);

  logic [PW-1:0] rem_q, rem_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [PW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [PW-1:0] src_rem;
  logic [QW-1:0] src_quo;
  logic [PW-1:0] src_dvs;
  logic [PW:0]   shifted;
  logic          ge;
  logic [PW-1:0] step_rem;
  logic [QW-1:0] step_quo;

  assign src_rem  = start ? '0 : rem_q;
  assign src_quo  = start ? dividend : quo_q;
  assign src_dvs  = start ? divisor : dvs_q;
  assign shifted  = {src_rem, src_quo[QW-1]};
  assign ge       = shifted >= {1'b0, src_dvs};
  assign step_rem = ge ? PW'(shifted - {1'b0, src_dvs})
                       : shifted[PW-1:0];
  assign step_quo = {src_quo[QW-2:0], ge};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = step_rem;
      quo_d  = step_quo;
      dvs_d  = divisor;
      cnt_d  = CW'(QW - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/gesture_frame_ctrl.sv
// Frame sequencer: gates the bbox tracker per frame, then computes
// box area and area/perimeter and hands one result per frame downstream.
module gesture_frame_ctrl
  import gesture_pkg::*;
#(
  parameter int SETTLE_CYC = 3,
  parameter int DW         = DW_DEF,
  parameter int PW         = PW_DEF,
  parameter int QW         = QW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_enable,
  input  logic [3:0]    cfg_skip,
  input  logic          vsync,
  input  logic [DW-1:0] trk_x_min,
  input  logic [DW-1:0] trk_x_max,
  input  logic [DW-1:0] trk_y_min,
  input  logic [DW-1:0] trk_y_max,
  input  logic [PW-1:0] trk_perim,
  output logic          trk_clr,
  output logic          trk_en,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [4*DW-1:0] res_box,
  output logic [QW-1:0] res_area,
  output logic [QW-1:0] res_ratio,
  output logic          res_empty,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    drop_cnt
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t          state_q, state_d;
  logic            vs_q, vs_prev_q;
  logic [3:0]      skip_q, skip_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [4*DW-1:0] box_q, box_d;
  logic [PW-1:0]   perim_q, perim_d;
  logic [QW-1:0]   area_q, area_d;
  logic [QW-1:0]   ratio_q, ratio_d;
  logic            empty_q, empty_d;
  logic            valid_q, valid_d;
  logic            clr_q, clr_d;
  logic            en_q, en_d;
  logic [15:0]     frame_q, frame_d;
  logic [7:0]      drop_q, drop_d;

  logic            rise, fall;
  logic [DW-1:0]   bx_min, bx_max, by_min, by_max;
  logic            empty_c;
  logic [QW-1:0]   area_c;
  logic            div_start, div_busy, div_done;
  logic [QW-1:0]   div_quo;

  assign rise = vs_q & ~vs_prev_q;
  assign fall = ~vs_q & vs_prev_q;

  assign {bx_min, bx_max, by_min, by_max} = box_q;
  assign empty_c = (bx_max < bx_min) || (by_max < by_min);
  assign area_c  = QW'(bx_max - bx_min) * QW'(by_max - by_min);

  assign div_start = (state_q == ST_MULT) && !empty_c
                     && (perim_q != '0);

  seq_div #(.QW(QW), .PW(PW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (area_c),
    .divisor  (perim_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    settle_d = settle_q;
    box_d    = box_q;
    perim_d  = perim_q;
    area_d   = area_q;
    ratio_d  = ratio_q;
    empty_d  = empty_q;
    valid_d  = valid_q;
    clr_d    = 1'b0;
    en_d     = en_q;
    frame_d  = frame_q;
    drop_d   = drop_q;

    // A start we cannot take is decimated first, else counted as missed
    if (rise) begin
      if (state_q == ST_ARM) begin
        if (cfg_enable) begin
          if (skip_q == 4'd0) begin
            clr_d   = 1'b1;
            en_d    = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            skip_d = skip_q - 4'd1;
          end
        end
      end else if (skip_q != 4'd0) begin
        skip_d = skip_q - 4'd1;
      end else if (drop_q != 8'hff) begin
        drop_d = drop_q + 8'd1;
      end
    end

    unique case (state_q)
      ST_ARM: ;
      ST_ACTIVE: begin
        if (fall) begin
          en_d     = 1'b0;
          skip_d   = cfg_skip;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          box_d   = {trk_x_min, trk_x_max,
                     trk_y_min, trk_y_max};
          perim_d = trk_perim;
          state_d = ST_MULT;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_MULT: begin
        if (empty_c) begin
          empty_d = 1'b1;
          area_d  = '0;
          ratio_d = '0;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end else begin
          empty_d = 1'b0;
          area_d  = area_c;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (perim_q == '0) begin
          ratio_d = '0;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end else if (div_done && !div_busy) begin
          ratio_d = div_quo;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          frame_d = frame_q + 16'd1;
          state_d = ST_ARM;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ARM;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      skip_q    <= '0;
      settle_q  <= '0;
      box_q     <= '0;
      perim_q   <= '0;
      area_q    <= '0;
      ratio_q   <= '0;
      empty_q   <= 1'b0;
      valid_q   <= 1'b0;
      clr_q     <= 1'b0;
      en_q      <= 1'b0;
      frame_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vsync;
      vs_prev_q <= vs_q;
      skip_q    <= skip_d;
      settle_q  <= settle_d;
      box_q     <= box_d;
      perim_q   <= perim_d;
      area_q    <= area_d;
      ratio_q   <= ratio_d;
      empty_q   <= empty_d;
      valid_q   <= valid_d;
      clr_q     <= clr_d;
      en_q      <= en_d;
      frame_q   <= frame_d;
      drop_q    <= drop_d;
    end
  end

  assign trk_clr   = clr_q;
  assign trk_en    = en_q;
  assign res_valid = valid_q;
  assign res_box   = box_q;
  assign res_area  = area_q;
  assign res_ratio = ratio_q;
  assign res_empty = empty_q;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_gesture_frame_ctrl.sv
// Directed bench for gesture_frame_ctrl: vector table of boxes plus
// sequences for strobes, decimation, back-pressure and reset.
module tb_gesture_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [3:0]  cfg_skip = '0;
  logic        vsync = 1'b0;
  logic [11:0] trk_x_min = '0, trk_x_max = '0;
  logic [11:0] trk_y_min = '0, trk_y_max = '0;
  logic [19:0] trk_perim = '0;
  logic        trk_clr, trk_en, res_valid;
  logic        res_ready = 1'b1;
  logic [47:0] res_box;
  logic [23:0] res_area, res_ratio;
  logic        res_empty;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  gesture_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable(cfg_enable), .cfg_skip(cfg_skip),
    .vsync(vsync),
    .trk_x_min(trk_x_min), .trk_x_max(trk_x_max),
    .trk_y_min(trk_y_min), .trk_y_max(trk_y_max),
    .trk_perim(trk_perim),
    .trk_clr(trk_clr), .trk_en(trk_en),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_box(res_box), .res_area(res_area),
    .res_ratio(res_ratio), .res_empty(res_empty),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] xmin, xmax, ymin, ymax;
    logic [19:0] perim;
    logic [23:0] area, ratio;
    logic        empty;
    int          lat;
  } vec_t;

  vec_t vecs [8];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic set_trk(input vec_t v);
    trk_x_min = v.xmin;
    trk_x_max = v.xmax;
    trk_y_min = v.ymin;
    trk_y_max = v.ymax;
    trk_perim = v.perim;
  endtask

  task automatic do_frame(input int len);
    vsync = 1'b1;
    repeat (len) @(negedge clk);
    vsync = 1'b0;
  endtask

  // cycles from the vsync fall to the first sampled res_valid
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_valid(input int cyc, output int n);
    n = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (res_valid) n++;
    end
  endtask

  task automatic chk_result(input string nm, input vec_t v);
    chk({nm, "_area"}, res_area, v.area);
    chk({nm, "_ratio"}, res_ratio, v.ratio);
    chk({nm, "_empty"}, res_empty, v.empty);
    chk({nm, "_box"}, res_box,
        {v.xmin, v.xmax, v.ymin, v.ymax});
  endtask

  initial begin
    int lat;
    int n;
    int pat [6];

    vecs[0] = '{12'd10, 12'd50, 12'd20, 12'd40, 20'd100,
                24'd800, 24'd8, 1'b0, 30};
    vecs[1] = '{12'd1024, 12'd0, 12'd5, 12'd9, 20'd50,
                24'd0, 24'd0, 1'b1, 6};
    vecs[2] = '{12'd0, 12'd3, 12'd0, 12'd3, 20'd0,
                24'd9, 24'd0, 1'b0, 7};
    vecs[3] = '{12'd0, 12'd4095, 12'd0, 12'd4095, 20'd1,
                24'd16769025, 24'd16769025, 1'b0, 30};
    vecs[4] = '{12'd100, 12'd100, 12'd7, 12'd200, 20'd7,
                24'd0, 24'd0, 1'b0, 30};
    vecs[5] = '{12'd5, 12'd17, 12'd3, 12'd8, 20'd7,
                24'd60, 24'd8, 1'b0, 30};
    vecs[6] = '{12'd2, 12'd1000, 12'd3, 12'd2000, 20'd1048575,
                24'd1993006, 24'd1, 1'b0, 30};
    vecs[7] = '{12'd0, 12'd10, 12'd9, 12'd8, 20'd5,
                24'd0, 24'd0, 1'b1, 6};

    repeat (3) @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_en", trk_en, 0);
    chk("rst_clr", trk_clr, 0);
    chk("rst_area", res_area, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    repeat (2) @(negedge clk);

    // clear/enable strobes around one frame
    set_trk(vecs[0]);
    vsync = 1'b1;
    @(negedge clk);
    chk("clr_early", trk_clr, 0);
    chk("en_early", trk_en, 0);
    @(negedge clk);
    chk("clr_pulse", trk_clr, 1);
    chk("en_start", trk_en, 1);
    @(negedge clk);
    chk("clr_end", trk_clr, 0);
    chk("en_hold", trk_en, 1);
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    chk("en_late", trk_en, 1);
    @(negedge clk);
    chk("en_off", trk_en, 0);
    wait_valid(lat);
    chk("seq_lat", lat, 28);
    chk_result("seq", vecs[0]);
    @(negedge clk);
    exp_frames++;
    chk("seq_frame", frame_cnt, exp_frames);

    for (int i = 0; i < 8; i++) begin
      set_trk(vecs[i]);
      do_frame(6);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk_result($sformatf("v%0d", i), vecs[i]);
      @(negedge clk);
      exp_frames++;
      chk($sformatf("v%0d_hs", i), res_valid, 0);
      chk($sformatf("v%0d_frame", i), frame_cnt, exp_frames);
      repeat (4) @(negedge clk);
    end

    // disabled: frame ignored, not a drop
    cfg_enable = 1'b0;
    do_frame(6);
    count_valid(50, n);
    chk("dis_pulses", n, 0);
    chk("dis_frame", frame_cnt, exp_frames);
    chk("dis_drop", drop_cnt, 0);
    cfg_enable = 1'b1;

    // decimation by 2
    pat = '{1, 0, 0, 1, 0, 0};
    set_trk(vecs[0]);
    cfg_skip = 4'd2;
    for (int f = 0; f < 6; f++) begin
      do_frame(6);
      count_valid(45, n);
      chk($sformatf("skip_f%0d", f + 1), n, pat[f]);
    end
    cfg_skip = 4'd0;
    exp_frames += 2;
    chk("skip_frame", frame_cnt, exp_frames);
    chk("skip_drop", drop_cnt, 0);

    // back-pressure across three frame starts
    res_ready = 1'b0;
    do_frame(6);
    wait_valid(lat);
    chk("bp_lat", lat, 30);
    for (int f = 0; f < 3; f++) begin
      do_frame(6);
      repeat (10) @(negedge clk);
    end
    chk("bp_valid", res_valid, 1);
    chk_result("bp", vecs[0]);
    chk("bp_drop", drop_cnt, 3);
    chk("bp_frame_held", frame_cnt, exp_frames);
    res_ready = 1'b1;
    @(negedge clk);
    exp_frames++;
    chk("bp_hs", res_valid, 0);
    chk("bp_frame", frame_cnt, exp_frames);
    count_valid(40, n);
    chk("bp_once", n, 0);
    chk("bp_drop_end", drop_cnt, 3);

    // reset in the middle of an active frame
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_en_pre", trk_en, 1);
    rst_n = 1'b0;
    vsync = 1'b0;
    #1;
    chk("ar_en", trk_en, 0);
    chk("ar_valid", res_valid, 0);
    chk("ar_frame", frame_cnt, 0);
    chk("ar_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    set_trk(vecs[5]);
    do_frame(6);
    wait_valid(lat);
    chk("ar_lat", lat, 30);
    chk_result("ar", vecs[5]);
    @(negedge clk);
    chk("ar_frame_post", frame_cnt, 1);
    chk("ar_drop_post", drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
